cpu_trace_buffer: RTL and testbench
===================================

// Module: cpu_trace_buffer
// PURPOSE
// Synthesizable on-chip trace recorder for the cpu core. Captures one entry per retired
// instruction (pc, register write-back, timestamp) into a DEPTH-entry buffer. Captured
// entries are drained later over a valid/ready port, so hardware runs can be diffed
// against the reference model log.
// Supports several capture modes (linear, ring, pc-triggered), a sticky overflow flag
// and a free-running cycle timestamp.
// PARAMETERS
// PC_WIDTH       10   width of trace_pc (matches instruction memory address width)
// DATA_WIDTH     16   width of register write-back data
// REG_ADDR_WIDTH 4    width of destination register index
// TS_WIDTH       16   timestamp width; wraps modulo 2**TS_WIDTH
// DEPTH          256  entries, power of two, >= 2
// PORTS
// clk            in   1                    clock, all logic on posedge
// rst            in   1                    asynchronous, active-low reset (0 = reset)
// mode           in   2                    0 off, 1 linear, 2 ring, 3 triggered; sampled on start
// start          in   1                    pulse: clear buffer and timestamp, begin capture per mode
// stop           in   1                    pulse: end capture, buffer contents kept
// trig_pc        in   PC_WIDTH             trigger address for mode 3, sampled on start
// trace_valid    in   1                    one instruction retired this cycle
// trace_pc       in   PC_WIDTH             pc of retired instruction
// trace_rd_we    in   1                    instruction writes a register
// trace_rd       in   REG_ADDR_WIDTH       destination register
// trace_rd_data  in   DATA_WIDTH           value written
// out_valid      out  1                    head entry available (count != 0)
// out_ready      in   1                    consumer accepts head entry
// out_data       out  TS+PC+1+RA+DATA      {ts, pc, rd_we, rd, rd_data}, MSB first
// count          out  $clog2(DEPTH)+1      entries held
// overflow       out  1                    sticky: an entry was dropped or overwritten
// state          out  2                    0 IDLE, 1 ARMED, 2 CAPTURE, 3 STOPPED
// BEHAVIOUR
// - Reset: state=IDLE, count=0, pointers=0, overflow=0, out_valid=0, out_data=0, ts=0.
// - FSM:
//   - IDLE/STOPPED + start: mode 0 -> IDLE; mode 3 -> ARMED; else -> CAPTURE.
//   - ARMED -> CAPTURE on the cycle trace_valid && trace_pc==trig_pc.
//   - CAPTURE -> STOPPED on stop, or on a push attempt at full in mode 1.
//   - ARMED -> STOPPED on stop.
//   - start in any state restarts capture.
//   - start and stop in the same cycle: start wins.
// - start clears count, pointers, overflow and ts in that cycle. No entry is recorded in
//   the start cycle.
// - ts: 0 in the first cycle after start, +1 every cycle while not IDLE, wraps silently.
// - Push: trace_valid in CAPTURE, or the trigger-hit beat in ARMED, which is recorded.
//   The entry holds the current ts and the trace fields. Visible on out_* the next cycle.
// - Pop: out_valid && out_ready. out_data is the head entry, read combinationally from
//   storage at the read pointer. Pops are allowed in every state except during reset.
// - Full, mode 1: push dropped, overflow=1, -> STOPPED.
// - Full, mode 3: push dropped, overflow=1, -> STOPPED.
// - Full, mode 2: oldest entry overwritten, read pointer advances, count stays DEPTH,
//   overflow=1.
// - Push and pop in the same cycle: count unchanged, no overflow even at full. When
//   empty, the pop is ignored and the push lands (count=1).
// - Pointers wrap modulo DEPTH. count ranges 0..DEPTH inclusive.
// - out_data holds its last value when out_valid=0 (don't-care for checkers).
// - rst mid-capture returns to the reset state immediately. No partial entry survives.
// TESTING
// 1. mode=1, start, trace_valid on capture cycles 0,1,3 with pc 5,6,7 -> count=3; pops
//    give pc 5,6,7 with ts 0,1,3.
// 2. DEPTH=4, mode=1, 6 beats pc 0..5 -> count=4, overflow=1, state=STOPPED; pops give
//    pc 0..3.
// 3. DEPTH=4, mode=2, 6 beats pc 0..5 -> count=4, overflow=1, state=CAPTURE; pops give
//    pc 2,3,4,5.
// 4. mode=3, trig_pc=20, beats pc 18,19,20,21 (rd_we=1, rd=3, data=42) -> count=2,
//    entries pc 20,21, rd 3, data 42.
// 5. DEPTH=4, mode=2, full, push pc 9 with out_ready=1 -> count=4, overflow=0, popped
//    entry is the old head, newest tail is pc 9.
// 6. rst=0 asserted mid-capture with count=3 -> count=0, state=IDLE, out_valid=0,
//    overflow=0 without waiting for clk.

Source files
------------

// File: rtl/cpu_trace_buffer_if.sv
// ----------------------------------------------------------------------------
// cpu_trace_buffer_if
// Bundles the control, retire-trace and drain signals of the cpu trace buffer.
//   master : drives mode/start/stop/trig_pc, the trace_* retire beat and
//            out_ready; observes out_valid/out_data/count/overflow/state
//   slave  : the trace buffer itself (mirror image of master)
// out_data layout is {ts, pc, rd_we, rd, rd_data}, MSB first.
// ----------------------------------------------------------------------------
interface cpu_trace_buffer_if #(
    parameter int PC_WIDTH       = 10,
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int TS_WIDTH       = 16,
    parameter int DEPTH          = 256
);
    localparam int ENTRY_WIDTH = TS_WIDTH + PC_WIDTH + 1 + REG_ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_WIDTH   = $clog2(DEPTH) + 1;

    logic [1:0]                mode;
    logic                      start;
    logic                      stop;
    logic [PC_WIDTH-1:0]       trig_pc;
    logic                      trace_valid;
    logic [PC_WIDTH-1:0]       trace_pc;
    logic                      trace_rd_we;
    logic [REG_ADDR_WIDTH-1:0] trace_rd;
    logic [DATA_WIDTH-1:0]     trace_rd_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [ENTRY_WIDTH-1:0]    out_data;
    logic [CNT_WIDTH-1:0]      count;
    logic                      overflow;
    logic [1:0]                state;

    modport master (
        output mode, start, stop, trig_pc,
        output trace_valid, trace_pc, trace_rd_we, trace_rd, trace_rd_data,
        output out_ready,
        input  out_valid, out_data, count, overflow, state
    );

    modport slave (
        input  mode, start, stop, trig_pc,
        input  trace_valid, trace_pc, trace_rd_we, trace_rd, trace_rd_data,
        input  out_ready,
        output out_valid, out_data, count, overflow, state
    );
endinterface

// File: rtl/cpu_trace_buffer.sv
// ----------------------------------------------------------------------------
// cpu_trace_buffer
// On-chip recorder of retired instructions. Each recorded entry holds the
// free-running timestamp plus the retire beat's pc and register write-back.
// Entries are drained in order over a valid/ready port.
// Capture modes: 0 off, 1 linear (stop when full), 2 ring (overwrite oldest),
// 3 triggered (arm, start recording at the beat whose pc equals trig_pc).
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cpu_trace_buffer_if.slave (control, trace beat, drain port, status)
// ----------------------------------------------------------------------------
module cpu_trace_buffer #(
    parameter int PC_WIDTH       = 10,
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int TS_WIDTH       = 16,
    parameter int DEPTH          = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    cpu_trace_buffer_if.slave bus
);
    localparam int PTR_WIDTH   = $clog2(DEPTH);
    localparam int CNT_WIDTH   = PTR_WIDTH + 1;
    localparam int ENTRY_WIDTH = TS_WIDTH + PC_WIDTH + 1 + REG_ADDR_WIDTH + DATA_WIDTH;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_STOPPED = 2'd3;

    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_RING = 2'd2;
    localparam logic [1:0] MODE_TRIG = 2'd3;

    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

    logic [1:0]             state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [PC_WIDTH-1:0]    trig_q, trig_d;
    logic [TS_WIDTH-1:0]    ts_q, ts_d;
    logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [ENTRY_WIDTH-1:0] hold_q;
    logic [ENTRY_WIDTH-1:0] mem [DEPTH];

    logic                   mem_we;
    logic [ENTRY_WIDTH-1:0] wr_entry;
    logic                   trig_hit;
    logic                   push_req;
    logic                   pop_req;
    logic                   full;

    assign wr_entry = {ts_q, bus.trace_pc, bus.trace_rd_we, bus.trace_rd, bus.trace_rd_data};

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        trig_d     = trig_q;
        ts_d       = ts_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;

        // The trigger beat itself is recorded, so it counts as a push.
        trig_hit = (state_q == ST_ARMED) && bus.trace_valid && (bus.trace_pc == trig_q);
        push_req = ((state_q == ST_CAPTURE) && bus.trace_valid) || trig_hit;
        pop_req  = (count_q != '0) && bus.out_ready;
        full     = (count_q == FULL_COUNT);

        if (bus.start) begin
            // start overrides everything else in its cycle, including stop
            // and any retire beat, which is not recorded.
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
            ts_d       = '0;
            mode_d     = bus.mode;
            trig_d     = bus.trig_pc;
            case (bus.mode)
                MODE_OFF:  state_d = ST_IDLE;
                MODE_TRIG: state_d = ST_ARMED;
                default:   state_d = ST_CAPTURE;
            endcase
        end else begin
            if (state_q != ST_IDLE) begin
                ts_d = ts_q + 1'b1;
            end

            if (trig_hit) begin
                state_d = ST_CAPTURE;
            end
            if (bus.stop && ((state_q == ST_ARMED) || (state_q == ST_CAPTURE))) begin
                state_d = ST_STOPPED;
            end

            // A simultaneous pop frees the head slot, so a push at full still
            // lands without loss.
            if (push_req && (!full || pop_req)) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (pop_req) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else if (push_req && (mode_q == MODE_RING)) begin
                // Full ring: the write slot is the head, so the oldest entry
                // is replaced and the head moves past it.
                mem_we     = 1'b1;
                wr_ptr_d   = wr_ptr_q + 1'b1;
                rd_ptr_d   = rd_ptr_q + 1'b1;
                overflow_d = 1'b1;
            end else if (push_req) begin
                overflow_d = 1'b1;
                state_d    = ST_STOPPED;
            end else if (pop_req) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
            end
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_OFF;
            trig_q     <= '0;
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            trig_q     <= trig_d;
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            hold_q     <= bus.out_data;
        end
    end

    // Entry storage carries no reset; a slot is only read once it has been
    // written, since reads are gated by a non-zero count.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    // When empty, out_data replays the last presented value from hold_q.
    assign bus.out_data  = (count_q != '0) ? mem[rd_ptr_q] : hold_q;
    assign bus.out_valid = (count_q != '0);
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// ----------------------------------------------------------------------------
// tb_cpu_trace_buffer
// Self-checking bench for cpu_trace_buffer with DEPTH=4. Directed scenarios
// check fixed expected values; a randomized phase is checked against a
// queue-based behavioural model updated on every clock.
// ----------------------------------------------------------------------------
module tb_cpu_trace_buffer;
    localparam int PCW   = 10;
    localparam int DW    = 16;
    localparam int RAW   = 4;
    localparam int TSW   = 16;
    localparam int DEPTH = 4;
    localparam int EW    = TSW + PCW + 1 + RAW + DW;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int compared = 0;
    int mismatched = 0;

    cpu_trace_buffer_if #(
        .PC_WIDTH(PCW), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .TS_WIDTH(TSW), .DEPTH(DEPTH)
    ) tif ();

    cpu_trace_buffer #(
        .PC_WIDTH(PCW), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .TS_WIDTH(TSW), .DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (tif)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue of recorded entries plus mode bookkeeping.
    logic [EW-1:0]  mQ[$];
    int             mTs;
    int             mState;
    logic           mOvf;
    int             mMode;
    logic [PCW-1:0] mTrig;

    function automatic int fPc(input logic [EW-1:0] e);
        return int'(e[DW+RAW+1 +: PCW]);
    endfunction

    function automatic int fTs(input logic [EW-1:0] e);
        return int'(e[EW-1 -: TSW]);
    endfunction

    task automatic modelReset();
        mQ.delete();
        mTs    = 0;
        mState = 0;
        mOvf   = 1'b0;
        mMode  = 0;
        mTrig  = '0;
    endtask

    task automatic idleInputs();
        tif.mode          = 2'd0;
        tif.start         = 1'b0;
        tif.stop          = 1'b0;
        tif.trig_pc       = '0;
        tif.trace_valid   = 1'b0;
        tif.trace_pc      = '0;
        tif.trace_rd_we   = 1'b0;
        tif.trace_rd      = '0;
        tif.trace_rd_data = '0;
        tif.out_ready     = 1'b0;
    endtask

    // Advance the model by one clock from the current inputs, then clock the
    // DUT and settle 1ns past the edge.
    task automatic step();
        logic          doPop, hit, push;
        logic [EW-1:0] e;
        int            prev;
        if (tif.start) begin
            mQ.delete();
            mTs   = 0;
            mOvf  = 1'b0;
            mMode = int'(tif.mode);
            mTrig = tif.trig_pc;
            mState = (mMode == 0) ? 0 : (mMode == 3) ? 1 : 2;
        end else begin
            prev  = mState;
            doPop = (mQ.size() > 0) && tif.out_ready;
            hit   = (prev == 1) && tif.trace_valid && (tif.trace_pc == mTrig);
            push  = ((prev == 2) && tif.trace_valid) || hit;
            e     = {mTs[TSW-1:0], tif.trace_pc, tif.trace_rd_we, tif.trace_rd, tif.trace_rd_data};
            if (hit) mState = 2;
            if (tif.stop && (prev == 1 || prev == 2)) mState = 3;
            if (doPop) void'(mQ.pop_front());
            if (push) begin
                if (mQ.size() < DEPTH) begin
                    mQ.push_back(e);
                end else if (mMode == 2) begin
                    void'(mQ.pop_front());
                    mQ.push_back(e);
                    mOvf = 1'b1;
                end else begin
                    mOvf   = 1'b1;
                    mState = 3;
                end
            end
            if (prev != 0) mTs = (mTs + 1) % (1 << TSW);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic startCapture(input int mode, input int trig);
        tif.mode    = 2'(mode);
        tif.trig_pc = PCW'(trig);
        tif.start   = 1'b1;
        step();
        tif.start   = 1'b0;
    endtask

    task automatic beat(input int pc, input logic we, input int rd, input int data);
        tif.trace_valid   = 1'b1;
        tif.trace_pc      = PCW'(pc);
        tif.trace_rd_we   = we;
        tif.trace_rd      = RAW'(rd);
        tif.trace_rd_data = DW'(data);
        step();
        tif.trace_valid   = 1'b0;
    endtask

    task automatic popEntry(output logic [EW-1:0] e);
        e = tif.out_data;
        tif.out_ready = 1'b1;
        step();
        tif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        idleInputs();
        modelReset();
        rst_n = 1'b0;
        #12;
        compared++;
        if (tif.count !== CW'(0)) begin
            mismatched++;
            $display("[TB] FAIL reset_count: got %0d expected 0", tif.count);
        end
        compared++;
        if (tif.state !== 2'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got %0d expected 0", tif.state);
        end
        compared++;
        if (tif.out_valid !== 1'b0 || tif.overflow !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got valid=%b ovf=%b expected 0 0", tif.out_valid, tif.overflow);
        end
        compared++;
        if (tif.out_data !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_out_data: got %h expected 0", tif.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_linear();
        logic [EW-1:0] e;
        int expPc[3] = '{5, 6, 7};
        int expTs[3] = '{0, 1, 3};
        startCapture(1, 0);
        beat(5, 1'b0, 0, 0);
        beat(6, 1'b0, 0, 0);
        step();
        beat(7, 1'b0, 0, 0);
        compared++;
        if (tif.count !== CW'(3)) begin
            mismatched++;
            $display("[TB] FAIL linear_count: got %0d expected 3", tif.count);
        end
        for (int i = 0; i < 3; i++) begin
            popEntry(e);
            compared++;
            if (fPc(e) != expPc[i] || fTs(e) != expTs[i]) begin
                mismatched++;
                $display("[TB] FAIL linear_entry%0d: got pc=%0d ts=%0d expected pc=%0d ts=%0d",
                         i, fPc(e), fTs(e), expPc[i], expTs[i]);
            end
        end
    endtask

    task automatic test_linear_full();
        logic [EW-1:0] e;
        startCapture(1, 0);
        for (int i = 0; i < 6; i++) beat(i, 1'b0, 0, 0);
        compared++;
        if (tif.count !== CW'(4) || tif.overflow !== 1'b1 || tif.state !== 2'd3) begin
            mismatched++;
            $display("[TB] FAIL linear_full_status: got count=%0d ovf=%b state=%0d expected 4 1 3",
                     tif.count, tif.overflow, tif.state);
        end
        for (int i = 0; i < 4; i++) begin
            popEntry(e);
            compared++;
            if (fPc(e) != i) begin
                mismatched++;
                $display("[TB] FAIL linear_full_pop%0d: got pc=%0d expected %0d", i, fPc(e), i);
            end
        end
    endtask

    task automatic test_ring();
        logic [EW-1:0] e;
        startCapture(2, 0);
        for (int i = 0; i < 6; i++) beat(i, 1'b0, 0, 0);
        compared++;
        if (tif.count !== CW'(4) || tif.overflow !== 1'b1 || tif.state !== 2'd2) begin
            mismatched++;
            $display("[TB] FAIL ring_status: got count=%0d ovf=%b state=%0d expected 4 1 2",
                     tif.count, tif.overflow, tif.state);
        end
        for (int i = 0; i < 4; i++) begin
            popEntry(e);
            compared++;
            if (fPc(e) != i + 2) begin
                mismatched++;
                $display("[TB] FAIL ring_pop%0d: got pc=%0d expected %0d", i, fPc(e), i + 2);
            end
        end
    endtask

    task automatic test_trigger();
        logic [EW-1:0] e;
        startCapture(3, 20);
        compared++;
        if (tif.state !== 2'd1) begin
            mismatched++;
            $display("[TB] FAIL trig_armed: got state=%0d expected 1", tif.state);
        end
        for (int pc = 18; pc <= 21; pc++) beat(pc, 1'b1, 3, 42);
        compared++;
        if (tif.count !== CW'(2) || tif.state !== 2'd2) begin
            mismatched++;
            $display("[TB] FAIL trig_status: got count=%0d state=%0d expected 2 2", tif.count, tif.state);
        end
        for (int i = 0; i < 2; i++) begin
            popEntry(e);
            compared++;
            if (e !== {TSW'(i + 2), PCW'(20 + i), 1'b1, RAW'(3), DW'(42)}) begin
                mismatched++;
                $display("[TB] FAIL trig_entry%0d: got %h expected pc=%0d ts=%0d rd=3 data=42",
                         i, e, 20 + i, i + 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] e;
        startCapture(2, 0);
        for (int i = 0; i < 4; i++) beat(i, 1'b0, 0, 0);
        tif.out_ready = 1'b1;
        e = tif.out_data;
        beat(9, 1'b0, 0, 0);
        tif.out_ready = 1'b0;
        compared++;
        if (fPc(e) != 0 || tif.count !== CW'(4) || tif.overflow !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_full: got popped pc=%0d count=%0d ovf=%b expected 0 4 0",
                     fPc(e), tif.count, tif.overflow);
        end
        for (int i = 0; i < 4; i++) begin
            popEntry(e);
            compared++;
            if (fPc(e) != ((i < 3) ? i + 1 : 9)) begin
                mismatched++;
                $display("[TB] FAIL b2b_drain%0d: got pc=%0d expected %0d", i, fPc(e), (i < 3) ? i + 1 : 9);
            end
        end
    endtask

    task automatic test_async_reset();
        startCapture(1, 0);
        for (int i = 0; i < 3; i++) beat(10 + i, 1'b0, 0, 0);
        compared++;
        if (tif.count !== CW'(3)) begin
            mismatched++;
            $display("[TB] FAIL areset_pre_count: got %0d expected 3", tif.count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (tif.count !== CW'(0) || tif.state !== 2'd0 || tif.out_valid !== 1'b0 || tif.overflow !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL areset_immediate: got count=%0d state=%0d valid=%b ovf=%b expected 0 0 0 0",
                     tif.count, tif.state, tif.out_valid, tif.overflow);
        end
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            tif.start         = ($urandom_range(0, 29) == 0);
            tif.mode          = 2'($urandom_range(0, 3));
            tif.trig_pc       = PCW'($urandom_range(0, 7));
            tif.stop          = !tif.start && ($urandom_range(0, 24) == 0);
            tif.trace_valid   = tif.stop ? 1'b0 : 1'($urandom_range(0, 1));
            tif.trace_pc      = PCW'($urandom_range(0, 7));
            tif.trace_rd_we   = 1'($urandom_range(0, 1));
            tif.trace_rd      = RAW'($urandom);
            tif.trace_rd_data = DW'($urandom);
            tif.out_ready     = ($urandom_range(0, 2) == 0);
            if (n == 0) begin
                tif.start = 1'b1;
                tif.mode  = 2'd2;
            end
            compared++;
            if (tif.out_valid !== (mQ.size() > 0)) begin
                mismatched++;
                $display("[TB] FAIL rand_valid@%0d: got %b expected %b", n, tif.out_valid, mQ.size() > 0);
            end else if (mQ.size() > 0 && tif.out_data !== mQ[0]) begin
                mismatched++;
                $display("[TB] FAIL rand_head@%0d: got %h expected %h", n, tif.out_data, mQ[0]);
            end
            step();
            compared++;
            if (tif.count !== CW'(mQ.size()) || tif.state !== 2'(mState) || tif.overflow !== mOvf) begin
                mismatched++;
                $display("[TB] FAIL rand_status@%0d: got count=%0d state=%0d ovf=%b expected %0d %0d %b",
                         n, tif.count, tif.state, tif.overflow, mQ.size(), mState, mOvf);
            end
        end
        idleInputs();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_linear();
        test_linear_full();
        test_ring();
        test_trigger();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
